// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) definitions used by both the streaming encoder and
// the correcting decoder: code types, parity positions, the data-to-codeword
// placement and the encode function.
package hamming_pkg;

   typedef logic [11:1] data_t;
   typedef logic [15:1] code_t;

   // Parity bits sit at the power-of-two codeword positions.
   localparam int unsigned P1 = 1;
   localparam int unsigned P2 = 2;
   localparam int unsigned P4 = 4;
   localparam int unsigned P8 = 8;

   // Occupancy classes of the codeword FIFO.
   typedef enum logic [1:0] {
      FILL_EMPTY   = 2'd0,
      FILL_PARTIAL = 2'd1,
      FILL_FULL    = 2'd2
   } fill_t;

   // Data-to-codeword map: cw[15:9]=d[11:5], cw[7:5]=d[4:2], cw[3]=d[1].
   // Parity positions are left at zero.
   function automatic code_t hamming_place(input data_t d);
      code_t cw;
      cw       = '0;
      cw[15:9] = d[11:5];
      cw[7:5]  = d[4:2];
      cw[3]    = d[1];
      return cw;
   endfunction

   // Full codeword: placed data plus the four even-parity bits.
   function automatic code_t hamming_encode(input data_t d);
      code_t cw;
      cw     = hamming_place(d);
      cw[P8] = ^d[11:5];
      cw[P4] = (^d[11:8]) ^ (^d[4:2]);
      cw[P2] = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      cw[P1] = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      return cw;
   endfunction

endpackage

// File: rtl/hamming_enc_stream_if.sv
// Stream bundle for the Hamming encoder: data-in handshake with error
// injection controls, and codeword-out handshake.
interface hamming_enc_stream_if;
   import hamming_pkg::*;

   logic       in_valid;
   logic       in_ready;
   data_t      in_data;
   logic       inj_en;
   logic [3:0] inj_pos;
   logic       out_valid;
   logic       out_ready;
   code_t      out_code;

   modport master (
      output in_valid, in_data, inj_en, inj_pos, out_ready,
      input  in_ready, out_valid, out_code
   );

   modport slave (
      input  in_valid, in_data, inj_en, inj_pos, out_ready,
      output in_ready, out_valid, out_code
   );

endinterface

// File: rtl/hamming_enc_stream_cw_fifo.sv
// Single-clock codeword FIFO. Occupancy is tracked by a small fill-state
// machine alongside the count so full/empty come straight from a register.
//
//   state        | meaning
//   -------------+----------------------------------------
//   FILL_EMPTY   | count == 0, nothing to present
//   FILL_PARTIAL | 0 < count < DEPTH, push and pop allowed
//   FILL_FULL    | count == DEPTH, pushes refused
module cw_fifo
   import hamming_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   fill_t            state;
   fill_t            state_nxt;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (state == FILL_FULL);
   assign empty   = (state == FILL_EMPTY);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   // Empty presents zero so the head never shows a discarded entry.
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Next occupancy and fill class; push+pop together leaves count unchanged.
   always_comb begin
      count_nxt = count;
      state_nxt = state;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
      if (count_nxt == '0)
         state_nxt = FILL_EMPTY;
      else if (count_nxt == CNT_W'(DEPTH))
         state_nxt = FILL_FULL;
      else
         state_nxt = FILL_PARTIAL;
   end

   // Fill state, count and pointers; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= FILL_EMPTY;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Entry storage, cleared on reset so nothing stale survives it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mem <= '{default: '0};
      else if (push_ok)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(15,11) encoder: encodes accepted words, optionally flips
// one codeword bit for decoder self-test, buffers codewords in a FIFO and
// keeps a running count of accepted words.
module hamming_enc_stream
   import hamming_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   hamming_enc_stream_if.slave    bus,
   output logic [CNT_W-1:0]       word_cnt
);

   logic  init_done;
   logic  fifo_full;
   logic  fifo_empty;
   logic  accept;
   logic  pop;
   code_t enc_code;
   code_t push_code;
   code_t head_code;
   logic [14:0] flip_mask;

   // in_ready depends only on registered state, never on out_ready.
   assign bus.in_ready  = init_done && !fifo_full;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = !fifo_empty;
   assign pop           = bus.out_valid && bus.out_ready;
   assign bus.out_code  = head_code;

   assign enc_code  = hamming_encode(bus.in_data);
   assign push_code = enc_code ^ flip_mask;

   // One-hot flip mask for the requested codeword position; position 0 is a no-op.
   always_comb begin
      flip_mask = '0;
      if (bus.inj_en && (bus.inj_pos != 4'd0))
         flip_mask[bus.inj_pos - 4'd1] = 1'b1;
   end

   // init_done holds off the first accept until one edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         init_done <= 1'b0;
      else
         init_done <= 1'b1;
   end

   // Accepted-word counter, wraps modulo 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         word_cnt <= '0;
      else if (accept)
         word_cnt <= word_cnt + CNT_W'(1);
   end

   cw_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (15)
   ) u_cw_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .pop   (pop),
      .din   (push_code),
      .dout  (head_code),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Bench for hamming_enc_stream: generic Hamming reference model with a
// per-cycle compare, plus literal codewords pinning the model.
module tb_hamming_enc_stream;
   import hamming_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] word_cnt;
   logic [3:0]  word_cnt4;

   int checks = 0;
   int failures = 0;

   hamming_enc_stream_if bus ();
   hamming_enc_stream_if bus4 ();

   always #5 clk = ~clk;

   hamming_enc_stream #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .word_cnt (word_cnt)
   );

   // Narrow-counter copy driven by the same stimulus, for wrap checks.
   hamming_enc_stream #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus4),
      .word_cnt (word_cnt4)
   );

   assign bus4.in_valid  = bus.in_valid;
   assign bus4.in_data   = bus.in_data;
   assign bus4.inj_en    = bus.inj_en;
   assign bus4.inj_pos   = bus.inj_pos;
   assign bus4.out_ready = bus.out_ready;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Generic Hamming: data fills non-power-of-two positions in ascending
   // order; parity at 2^b covers every position with bit b set.
   function automatic logic [15:1] model_encode(input logic [11:1] d);
      logic [15:1] cw;
      logic        p;
      int          j;
      cw = '0;
      j  = 1;
      for (int k = 1; k <= 15; k++) begin
         if ((k & (k - 1)) != 0) begin
            cw[k] = d[j];
            j++;
         end
      end
      for (int b = 0; b < 4; b++) begin
         p = 1'b0;
         for (int k = 1; k <= 15; k++)
            if ((((k >> b) & 1) == 1) && (k != (1 << b)))
               p = p ^ cw[k];
         cw[1 << b] = p;
      end
      return cw;
   endfunction

   function automatic int model_syndrome(input logic [15:1] cw);
      int s;
      s = 0;
      for (int k = 1; k <= 15; k++)
         if (cw[k]) s = s ^ k;
      return s;
   endfunction

   function automatic logic [11:1] model_decode(input logic [15:1] cw_in);
      logic [15:1] cw;
      logic [11:1] d;
      int          s;
      int          j;
      cw = cw_in;
      s  = model_syndrome(cw);
      if (s != 0) cw[s] = ~cw[s];
      d = '0;
      j = 1;
      for (int k = 1; k <= 15; k++) begin
         if ((k & (k - 1)) != 0) begin
            d[j] = cw[k];
            j++;
         end
      end
      return d;
   endfunction

   // Reference state: expected FIFO contents, accept count, init flag.
   logic [15:1] mq[$];
   int          mcnt = 0;
   bit          minit = 1'b0;

   task automatic model_step();
      logic [15:1] c;
      bit          acc;
      bit          pp;
      acc = bus.in_valid && minit && (mq.size() < DEPTH);
      pp  = (mq.size() > 0) && bus.out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) begin
         c = model_encode(bus.in_data);
         if (bus.inj_en && (bus.inj_pos != 4'd0))
            c[bus.inj_pos] = ~c[bus.inj_pos];
         mq.push_back(c);
      end
      if (acc) mcnt = mcnt + 1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mcnt  <= 0;
         minit <= 1'b0;
      end else begin
         model_step();
         minit <= 1'b1;
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, minit && (mq.size() < DEPTH)});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0)
         chk("out_code", {17'd0, bus.out_code}, {17'd0, mq[0]});
      if (!rst_n)
         chk("rst_out_code", {17'd0, bus.out_code}, 32'd0);
      chk("word_cnt", {16'd0, word_cnt}, {16'd0, mcnt[15:0]});
      chk("word_cnt4", {28'd0, word_cnt4}, {28'd0, mcnt[3:0]});
   end

   // Offer one word (waiting for in_ready), return at the negedge after accept.
   task automatic send(input logic [11:1] d, input bit ie, input logic [3:0] ip);
      int t;
      t = 0;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.inj_en   = ie;
      bus.inj_pos  = ip;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.inj_en   = 1'b0;
      bus.inj_pos  = 4'd0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      logic [11:1] d;
      bit          ie;
      logic [3:0]  ip;
      logic [15:1] exp;
   } lit_t;

   lit_t        lits[7];
   logic [15:1] exp3[3];
   logic [15:1] c;
   int          got;
   int          gaps;
   bit          will_acc;

   initial begin
      lits[0] = '{11'h000, 1'b0, 4'd0, 15'h0000};
      lits[1] = '{11'h7FF, 1'b0, 4'd0, 15'h7FFF};
      lits[2] = '{11'h001, 1'b0, 4'd0, 15'h0007};
      lits[3] = '{11'h400, 1'b0, 4'd0, 15'h408B};
      lits[4] = '{11'h000, 1'b1, 4'd5, 15'h0010};
      lits[5] = '{11'h000, 1'b1, 4'd0, 15'h0000};
      lits[6] = '{11'h123, 1'b0, 4'd0, 15'h1215};
      exp3[0] = 15'h0007;
      exp3[1] = 15'h408B;
      exp3[2] = 15'h7FFF;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.inj_en    = 1'b0;
      bus.inj_pos   = 4'd0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
      rst_n = 1'b1;
      #1 chk("ready_at_release", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      chk("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

      // Literal codewords, one cycle after accept with an empty FIFO.
      foreach (lits[i]) begin
         send(lits[i].d, lits[i].ie, lits[i].ip);
         chk("lit_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("lit_code", {17'd0, bus.out_code}, {17'd0, lits[i].exp});
         @(negedge clk);
      end

      // Injection sweep through the reference decoder.
      for (int p = 1; p <= 15; p++) begin
         send(11'h5A3, 1'b1, 4'(p));
         c = bus.out_code;
         chk("inj_syndrome", model_syndrome(c), p);
         chk("inj_decoded", {21'd0, model_decode(c)}, {21'd0, 11'h5A3});
         @(negedge clk);
      end

      // Backpressure: two accepted, third refused until the consumer drains.
      do_reset();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 11'h001;
      @(negedge clk);
      bus.in_data   = 11'h400;
      @(negedge clk);
      bus.in_data   = 11'h7FF;
      chk("bp_third_refused", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_cnt2", {16'd0, word_cnt}, 32'd2);
      @(negedge clk);
      chk("bp_hold_code", {17'd0, bus.out_code}, 32'h0007);
      bus.out_ready = 1'b1;
      got = 0;
      for (int t = 0; t < 20 && got < 3; t++) begin
         will_acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid) begin
            chk("bp_order", {17'd0, bus.out_code}, {17'd0, exp3[got]});
            got++;
         end
         @(negedge clk);
         if (will_acc) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("bp_got3", got, 3);
      chk("bp_word_cnt", {16'd0, word_cnt}, 32'd3);
      @(negedge clk);

      // Steady state: 100 back-to-back words, one output per cycle.
      do_reset();
      bus.out_ready = 1'b1;
      gaps = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == 16) begin
            chk("ss_cnt16", {16'd0, word_cnt}, 32'd16);
            chk("ss_wrap4", {28'd0, word_cnt4}, 32'd0);
         end
         if (i >= 1 && !bus.out_valid) gaps++;
         bus.in_valid = 1'b1;
         bus.in_data  = 11'((i * 37 + 5) % 2048);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("ss_gaps", gaps, 0);
      chk("ss_word_cnt", {16'd0, word_cnt}, 32'd100);
      chk("ss_word_cnt4", {28'd0, word_cnt4}, 32'd4);
      repeat (2) @(negedge clk);

      // Reset with the FIFO full.
      bus.out_ready = 1'b0;
      send(11'h0AA, 1'b0, 4'd0);
      send(11'h055, 1'b0, 4'd0);
      chk("mr_full", {31'd0, bus.in_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mr_word_cnt", {16'd0, word_cnt}, 32'd0);
      chk("mr_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      bus.out_ready = 1'b1;
      rst_n = 1'b1;
      #1 chk("mr_ready_at_release", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      chk("mr_ready_after", {31'd0, bus.in_ready}, 32'd1);
      chk("mr_no_stale", {31'd0, bus.out_valid}, 32'd0);
      send(11'h123, 1'b0, 4'd0);
      chk("mr_first_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("mr_first_code", {17'd0, bus.out_code}, 32'h1215);
      chk("mr_first_cnt", {16'd0, word_cnt}, 32'd1);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
